spi_reg_ctrl: RTL and testbench

- Command/register-access controller behind the byte-level SPI slave datapath.
- Parses each CS-framed SPI transaction: command byte = {rw, addr}, then burst data bytes with address auto-increment.
- Sequences read/write requests to an on-chip 8-bit register file over a req/ack handshake.
- Supplies the next MISO byte to the slave shifter; enforces ack timeout; reports overrun and error status.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_ack_timer.sv | 28 ++
 rtl/spi_reg_ctrl.sv | 127 ++++++++++++
 tb/tb_spi_reg_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared state encoding, command/status byte layout and fill values for the SPI register controller.
package spi_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_WR_DATA = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_REQ  = 3'd4;
    localparam logic [2:0] ST_RD_WAIT = 3'd5;

    localparam int CMD_RW_BIT   = 7;
    localparam int STAT_OVR_BIT = 7;
    localparam int STAT_ERR_BIT = 6;
    localparam int STAT_CNT_MSB = 5;

    localparam logic [7:0] TO_FILL_BYTE = 8'hFF;

    function automatic logic [7:0] status_byte(input logic o, input logic e, input logic [7:0] cnt);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_CNT_MSB:0] = cnt[STAT_CNT_MSB:0];
        s[STAT_ERR_BIT]   = e;
        s[STAT_OVR_BIT]   = o;
        return s;
    endfunction

endpackage

// File: rtl/spi_ack_timer.sv
// Ack timeout counter: clears while idle, counts unacked request cycles, holds at TO_CYC.
// Latency: expired is a combinational compare of the registered count; no backpressure.
module spi_ack_timer #(
    parameter int TO_CYC = 255
) (
    input  logic clk,
    input  logic ar,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TO_CYC + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(TO_CYC));

    always_ff @(posedge clk) begin
        if (!ar) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command parser and register-file sequencer: {rw,addr} command then auto-incrementing bursts.
// Latency: reg_req one cycle after the accepted byte, tx_ld one cycle after ack; bytes arriving mid-request are dropped (ovr).
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int AW     = 7,
    parameter int TO_CYC = 255
) (
    input  logic          clk,
    input  logic          ar,
    input  logic          frm_start,
    input  logic          frm_end,
    input  logic          rx_vld,
    input  logic [7:0]    rx_byte,
    output logic          tx_ld,
    output logic [7:0]    tx_byte,
    output logic          reg_req,
    output logic          reg_we,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    input  logic          reg_ack,
    input  logic [7:0]    reg_rdata,
    output logic          busy,
    output logic          ovr,
    output logic          err,
    output logic [7:0]    frame_cnt
);

    logic [2:0]    state;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic          start_pend;
    logic          end_pend;

    logic in_req;
    logic expired;
    logic done;
    logic timeout;
    logic take_start;
    logic take_end;

    assign in_req  = (state == ST_WR_REQ) || (state == ST_RD_REQ);
    assign done    = in_req && (reg_ack || expired);
    assign timeout = in_req && expired && !reg_ack;

    // Frame boundaries seen during a handshake are deferred until it finishes.
    assign take_start = in_req ? (done && (start_pend || frm_start)) : frm_start;
    assign take_end   = in_req ? (done && (end_pend || frm_end))     : frm_end;

    assign reg_req   = in_req && !expired;
    assign reg_we    = (state == ST_WR_REQ);
    assign reg_addr  = addr;
    assign reg_wdata = wdata;
    assign busy      = (state != ST_IDLE);

    spi_ack_timer #(.TO_CYC(TO_CYC)) u_timer (
        .clk     (clk),
        .ar      (ar),
        .clr     (!in_req),
        .en      (in_req && !reg_ack),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!ar) begin
            state      <= ST_IDLE;
            tx_ld      <= 1'b0;
            tx_byte    <= 8'h00;
            addr       <= '0;
            wdata      <= 8'h00;
            ovr        <= 1'b0;
            err        <= 1'b0;
            frame_cnt  <= 8'h00;
            start_pend <= 1'b0;
            end_pend   <= 1'b0;
        end else begin
            tx_ld <= 1'b0;

            if (in_req) begin
                if (rx_vld && !frm_end)
                    ovr <= 1'b1;
                if (done) begin
                    start_pend <= 1'b0;
                    end_pend   <= 1'b0;
                end else begin
                    if (frm_start) start_pend <= 1'b1;
                    if (frm_end)   end_pend   <= 1'b1;
                end
                if (timeout)
                    err <= 1'b1;
                if (reg_ack)
                    addr <= addr + AW'(1);
            end

            if (take_start) begin
                state     <= ST_CMD;
                frame_cnt <= frame_cnt + 8'd1;
                tx_byte   <= status_byte(ovr, err, frame_cnt);
                tx_ld     <= 1'b1;
            end else if (take_end) begin
                state <= ST_IDLE;
            end else if (done) begin
                if (state == ST_WR_REQ) begin
                    state <= ST_WR_DATA;
                end else begin
                    tx_byte <= reg_ack ? reg_rdata : TO_FILL_BYTE;
                    tx_ld   <= 1'b1;
                    state   <= ST_RD_WAIT;
                end
            end else if (rx_vld && !in_req) begin
                case (state)
                    ST_CMD: begin
                        addr  <= rx_byte[AW-1:0];
                        state <= rx_byte[CMD_RW_BIT] ? ST_RD_REQ : ST_WR_DATA;
                    end
                    ST_WR_DATA: begin
                        wdata <= rx_byte;
                        state <= ST_WR_REQ;
                    end
                    ST_RD_WAIT: state <= ST_RD_REQ;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench: register-file responder with programmable ack delay, tx_ld monitor, linear scenario.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       ar;
    logic       frm_start, frm_end, rx_vld;
    logic [7:0] rx_byte;
    logic       tx_ld;
    logic [7:0] tx_byte;
    logic       reg_req, reg_we;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_ack;
    logic [7:0] reg_rdata;
    logic       busy, ovr, err;
    logic [7:0] frame_cnt;

    always #5 clk = ~clk;

    spi_reg_ctrl #(.AW(7), .TO_CYC(255)) dut (
        .clk       (clk),
        .ar        (ar),
        .frm_start (frm_start),
        .frm_end   (frm_end),
        .rx_vld    (rx_vld),
        .rx_byte   (rx_byte),
        .tx_ld     (tx_ld),
        .tx_byte   (tx_byte),
        .reg_req   (reg_req),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_ack   (reg_ack),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .ovr       (ovr),
        .err       (err),
        .frame_cnt (frame_cnt)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]  mem [0:127];
    int          ack_dly = 2;   // 0 = never acknowledge
    int          req_cyc = 0;
    logic [7:0]  tx_q  [$];
    logic [7:0]  ack_q [$];
    logic [15:0] wr_q  [$];
    int          tx_cnt = 0;

    // Register file: acks on the ack_dly-th cycle that reg_req is seen high.
    initial begin : responder
        reg_ack   = 1'b0;
        reg_rdata = 8'h00;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[5] = 8'hA1;
        mem[6] = 8'hA2;
        mem[7] = 8'hA3;
        forever begin
            @(negedge clk);
            reg_ack = 1'b0;
            if (reg_req === 1'b1) begin
                req_cyc++;
                if (ack_dly > 0 && req_cyc == ack_dly) begin
                    reg_ack   = 1'b1;
                    reg_rdata = mem[reg_addr];
                    ack_q.push_back({1'b0, reg_addr});
                    if (reg_we) begin
                        mem[reg_addr] = reg_wdata;
                        wr_q.push_back({1'b0, reg_addr, reg_wdata});
                    end
                end
            end else begin
                req_cyc = 0;
            end
        end
    end

    initial begin : tx_monitor
        forever begin
            @(negedge clk);
            if (tx_ld === 1'b1) begin
                tx_q.push_back(tx_byte);
                tx_cnt++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_start();
        frm_start = 1'b1;
        step();
        frm_start = 1'b0;
    endtask

    task automatic pulse_end();
        frm_end = 1'b1;
        step();
        frm_end = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_vld  = 1'b1;
        rx_byte = b;
        step();
        rx_vld  = 1'b0;
    endtask

    task automatic do_reset();
        ar = 1'b0;
        idle(3);
        ar = 1'b1;
    endtask

    initial begin : stimulus
        int n;
        int t0;
        ar = 1'b0; frm_start = 1'b0; frm_end = 1'b0; rx_vld = 1'b0; rx_byte = 8'h00;
        do_reset();

        check("rst_tx_ld",     tx_ld,     1'b0);
        check("rst_tx_byte",   tx_byte,   8'h00);
        check("rst_reg_req",   reg_req,   1'b0);
        check("rst_reg_we",    reg_we,    1'b0);
        check("rst_reg_addr",  reg_addr,  7'h00);
        check("rst_busy",      busy,      1'b0);
        check("rst_ovr",       ovr,       1'b0);
        check("rst_err",       err,       1'b0);
        check("rst_frame_cnt", frame_cnt, 8'h00);
        tx_q.delete(); ack_q.delete(); wr_q.delete();

        // Burst read of 5..7 plus a prefetch of 8 cut by frm_end.
        ack_dly = 2;
        pulse_start();
        check("rd_busy_after_start", busy, 1'b1);
        send(8'h85);
        check("rd_req_latency", reg_req,  1'b1);
        check("rd_req_we",      reg_we,   1'b0);
        check("rd_req_addr",    reg_addr, 7'h05);
        idle(6); send(8'h00);
        idle(6); send(8'h00);
        idle(6); send(8'h00);
        pulse_end();
        idle(6);
        check("rd_tx_count", tx_q.size(), 4);
        check("rd_tx0", tx_q[0], 8'h00);
        check("rd_tx1", tx_q[1], 8'hA1);
        check("rd_tx2", tx_q[2], 8'hA2);
        check("rd_tx3", tx_q[3], 8'hA3);
        check("rd_ack_count", ack_q.size(), 4);
        check("rd_addr0", ack_q[0], 8'h05);
        check("rd_addr1", ack_q[1], 8'h06);
        check("rd_addr2", ack_q[2], 8'h07);
        check("rd_addr3", ack_q[3], 8'h08);
        check("rd_frame_cnt", frame_cnt, 8'h01);
        check("rd_busy_end",  busy, 1'b0);

        // Write burst wrapping 7F -> 00.
        wr_q.delete();
        pulse_start();
        send(8'h7E);
        send(8'h11); idle(5);
        send(8'h22); idle(5);
        send(8'h33); idle(5);
        pulse_end();
        check("wr_busy_after_end", busy, 1'b0);
        check("wr_count", wr_q.size(), 3);
        check("wr0", wr_q[0], 16'h7E11);
        check("wr1", wr_q[1], 16'h7F22);
        check("wr2", wr_q[2], 16'h0033);
        check("wr_frame_cnt", frame_cnt, 8'h02);

        // Read timeout with no ack.
        do_reset();
        ack_dly = 0;
        pulse_start();
        send(8'h83);
        n = 0;
        while (reg_req === 1'b1 && n < 400) begin
            n++;
            step();
        end
        check("to_req_cycles", n, 255);
        step();
        check("to_err",     err,      1'b1);
        check("to_tx_ld",   tx_ld,    1'b1);
        check("to_tx_byte", tx_byte,  8'hFF);
        check("to_addr",    reg_addr, 7'h03);
        pulse_end();
        check("to_busy_end", busy, 1'b0);
        pulse_start();
        check("to_next_status_ld", tx_ld,   1'b1);
        check("to_next_status",    tx_byte, 8'h41);
        pulse_end();

        // Overrun during a write request.
        ack_dly = 6;
        wr_q.delete();
        pulse_start();
        check("ovr_status", tx_byte, 8'h42);
        send(8'h10);
        send(8'h5A);
        send(8'hC3);
        idle(8);
        check("ovr_flag",     ovr, 1'b1);
        check("ovr_wr_count", wr_q.size(), 1);
        check("ovr_wr_data",  wr_q[0], 16'h105A);
        check("ovr_addr",     reg_addr, 7'h11);
        check("ovr_busy",     busy, 1'b1);
        pulse_end();

        // frm_end during a read request: handshake completes, nothing transmitted.
        ack_dly = 10;
        ack_q.delete();
        pulse_start();
        step();
        t0 = tx_cnt;
        send(8'h82);
        frm_end = 1'b1;
        n = 0;
        while (reg_req === 1'b1 && n < 50) begin
            n++;
            step();
            frm_end = 1'b0;
        end
        frm_end = 1'b0;
        check("end_req_cycles", n, 10);
        check("end_busy",       busy, 1'b0);
        check("end_no_tx",      tx_cnt, t0);
        check("end_ack_count",  ack_q.size(), 1);
        check("end_ack_addr",   ack_q[0], 8'h02);

        // frm_start while waiting for write data restarts the frame.
        ack_dly = 2;
        wr_q.delete();
        pulse_start();
        send(8'h05);
        idle(2);
        pulse_start();
        check("rs_tx_ld",     tx_ld,     1'b1);
        check("rs_status",    tx_byte,   8'hC5);
        check("rs_frame_cnt", frame_cnt, 8'h06);
        check("rs_busy",      busy,      1'b1);
        idle(4);
        check("rs_no_write",  wr_q.size(), 0);
        check("rs_no_req",    reg_req,   1'b0);
        pulse_end();
        check("rs_busy_end",  busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
